counter_sched: RTL
==================

COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 SHALL have port clock, input, 1, sole clock; all state changes on its rising edge.
REQ-002 SHALL have port clear, input, 1, reset; synchronous, active-high.
REQ-003 SHALL have port req0, input, 1, requester 0 asks for a count run; held high for the whole run.
REQ-004 SHALL have port req1, input, 1, requester 1 asks for a count run; held high for the whole run.
REQ-005 SHALL have port dir0, input, 1, requester 0 direction (1 up, 0 down); sampled at grant.
REQ-006 SHALL have port dir1, input, 1, requester 1 direction (1 up, 0 down); sampled at grant.
REQ-007 SHALL have port steps0, input, 3, requester 0 run length; 0 means 8; sampled at grant.
REQ-008 SHALL have port steps1, input, 3, requester 1 run length; 0 means 8; sampled at grant.
REQ-009 SHALL have port gnt0, output, 1, requester 0 owns the counter.
REQ-010 SHALL have port gnt1, output, 1, requester 1 owns the counter.
REQ-011 SHALL have port count, output, 3, shared counter value.
REQ-012 SHALL have port busy, output, 1, high in RUN.
REQ-013 SHALL have port done, output, 1, one-cycle pulse on normal run completion.

Function
REQ-014 SHALL implement states IDLE, RUN, DONE; all outputs registered.
REQ-015 IDLE: on an edge with req0|req1 high, SHALL pick an owner, latch its dir and steps (0->8) into remaining, set gnt<owner>=1 and go to RUN.
REQ-016 Arbitration SHALL be round-robin: with both requesting, the requester not served last wins; a single requester always wins.
REQ-017 RUN: each edge SHALL move count by +1 (dir=1) or -1 (dir=0) modulo 8 (7->0, 0->7) and decrement remaining.
REQ-018 RUN: on the edge where remaining==1, SHALL perform the final step, go to DONE, clear gnt and assert done.
REQ-019 DONE: SHALL hold done=1 for exactly one cycle, then go to IDLE; no arbitration in DONE.
REQ-020 Abort: if the owner's req is low on a RUN edge, SHALL not step, SHALL clear gnt, SHALL go to IDLE, SHALL not pulse done, and count SHALL keep its value.
REQ-021 The non-owner's req SHALL be ignored during RUN and DONE.
REQ-022 count SHALL persist across runs; only clear resets it.
REQ-023 gnt0 and gnt1 SHALL never be high together; busy SHALL equal gnt0|gnt1.
REQ-024 Latency: grant one edge after req is seen in IDLE; N steps take N edges; done at most N+1 cycles after grant.

Reset
REQ-025 clear high on an edge SHALL force IDLE, count=0, gnt0=gnt1=0, busy=0, done=0, remaining=0, last-served=1 (req0 wins the first tie).
REQ-026 clear SHALL override every other input, including mid-run, with no done pulse.

Configuration
REQ-027 Macro COUNTER_SCHED_BOUNCE_EN, when defined: in RUN, an up step from 7 SHALL instead go to 6 and a down step from 0 SHALL go to 1, with the latched direction reversed for the rest of the run; remaining decrements as normal.
REQ-028 Without COUNTER_SCHED_BOUNCE_EN: SHALL use modulo-8 wrap only, and direction SHALL stay fixed for the run.

Verification
REQ-029 After clear, req0=1, dir0=1, steps0=3 -> gnt0 next cycle; count 1,2,3; done pulses once; gnt0 drops with done.
REQ-030 Both req high from reset, steps=1 each -> req0 served first; after IDLE, req1 served; gnt never overlaps.
REQ-031 count=6, req1=1, dir1=1, steps1=4 -> count 7,0,1,2 without macro; with macro count 7,6,5,4.
REQ-032 count=0, req0=1, dir0=0, steps0=0 -> 8 down steps 7..0; done after the 8th step.
REQ-033 During a run with steps0=5, drop req0 after 2 steps -> count=2, gnt0=0, no done, IDLE next cycle.
REQ-034 clear asserted during RUN at count=5 -> next cycle count=0, gnt=0, busy=0, done=0.

Source files
------------

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - two-requester round-robin scheduler driving a shared 3-bit up/down counter
// Optional feature: COUNTER_SCHED_BOUNCE_EN (reflect at 0/7 instead of wrapping)
module counter_sched (
    input  logic       clock,
    input  logic       clear,
    input  logic       req0,
    input  logic       req1,
    input  logic       dir0,
    input  logic       dir1,
    input  logic [2:0] steps0,
    input  logic [2:0] steps1,
    output logic       gnt0,
    output logic       gnt1,
    output logic [2:0] count,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t     r_state;
    logic [2:0] r_count;
    logic [3:0] r_remaining;
    logic       r_dir;
    logic       r_owner;
    logic       r_last;
    logic       r_gnt0;
    logic       r_gnt1;
    logic       r_busy;
    logic       r_done;

    logic       w_pick1;
    logic       w_owner_req;
    logic [2:0] w_sel_steps;
    logic [3:0] w_run_len;
    logic [2:0] w_next_count;
    logic       w_flip;

    // r_last==1 means requester 1 was served last, so requester 0 wins a tie.
    assign w_pick1     = req1 & (~req0 | ~r_last);
    assign w_owner_req = r_owner ? req1 : req0;
    assign w_sel_steps = w_pick1 ? steps1 : steps0;
    assign w_run_len   = (w_sel_steps == 3'd0) ? 4'd8 : {1'b0, w_sel_steps};

    always_comb begin
        w_flip       = 1'b0;
        w_next_count = r_dir ? (r_count + 3'd1) : (r_count - 3'd1);
`ifdef COUNTER_SCHED_BOUNCE_EN
        if (r_dir && r_count == 3'd7) begin
            w_next_count = 3'd6;
            w_flip       = 1'b1;
        end else if (!r_dir && r_count == 3'd0) begin
            w_next_count = 3'd1;
            w_flip       = 1'b1;
        end
`endif
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_count     <= 3'd0;
            r_remaining <= 4'd0;
            r_dir       <= 1'b0;
            r_owner     <= 1'b0;
            r_last      <= 1'b1;
            r_gnt0      <= 1'b0;
            r_gnt1      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (req0 | req1) begin
                        r_owner     <= w_pick1;
                        r_last      <= w_pick1;
                        r_dir       <= w_pick1 ? dir1 : dir0;
                        r_remaining <= w_run_len;
                        r_gnt0      <= ~w_pick1;
                        r_gnt1      <= w_pick1;
                        r_busy      <= 1'b1;
                        r_state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!w_owner_req) begin
                        // Abort: owner withdrew, counter is left untouched.
                        r_gnt0  <= 1'b0;
                        r_gnt1  <= 1'b0;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_count     <= w_next_count;
                        r_remaining <= r_remaining - 4'd1;
                        if (w_flip) begin
                            r_dir <= ~r_dir;
                        end
                        if (r_remaining == 4'd1) begin
                            r_gnt0  <= 1'b0;
                            r_gnt1  <= 1'b0;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_gnt0  <= 1'b0;
                    r_gnt1  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign gnt0  = r_gnt0;
    assign gnt1  = r_gnt1;
    assign count = r_count;
    assign busy  = r_busy;
    assign done  = r_done;

endmodule
